// File: rtl/mef_irrigacao_pkg.sv
// Shared encodings for the irrigation sequencer: FSM states, mef1 codes to the validator, error codes.
package mef_irrigacao_pkg;

    localparam int unsigned MEF1_W = 2;
    localparam int unsigned CODE_W = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENCHENDO = 3'd1,
        S_REGA_ASP = 3'd2,
        S_REGA_GOT = 3'd3,
        S_LIMPEZA  = 3'd4,
        S_ERRO     = 3'd5
    } estado_t;

    typedef enum logic [CODE_W-1:0] {
        ERR_NONE  = 2'b00,
        ERR_VALID = 2'b01,
        ERR_REQS  = 2'b10,
        ERR_NIVEL = 2'b11
    } erro_t;

    localparam logic [MEF1_W-1:0] MEF1_IDLE = 2'b00;
    localparam logic [MEF1_W-1:0] MEF1_ENCH = 2'b01;
    localparam logic [MEF1_W-1:0] MEF1_LIMP = 2'b10;
    localparam logic [MEF1_W-1:0] MEF1_REGA = 2'b11;

    // Validator rega encoding that confirms each irrigation mode
    localparam logic [1:0] REGA_MODO_ASP = 2'b10;
    localparam logic [1:0] REGA_MODO_GOT = 2'b01;

    function automatic logic [MEF1_W-1:0] mef1_de(input estado_t s);
        case (s)
            S_ENCHENDO:             return MEF1_ENCH;
            S_LIMPEZA:              return MEF1_LIMP;
            S_REGA_ASP, S_REGA_GOT: return MEF1_REGA;
            default:                return MEF1_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/timer_descendente.sv
// Tick-driven down-counter; done_c flags the tick that completes the loaded duration.
module timer_descendente #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_c = tick && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mef_irrigacao.sv
// Irrigation sequencer: fill, sprinkler/drip runs, periodic cleaning and error handling.
module mef_irrigacao
    import mef_irrigacao_pkg::*;
#(
    parameter int unsigned T_ASP        = 8,
    parameter int unsigned T_GOT        = 16,
    parameter int unsigned T_LIMP       = 4,
    parameter int unsigned T_FILL       = 32,
    parameter int unsigned N_REGAS_LIMP = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              asp_req,
    input  logic              got_req,
    input  logic [1:0]        rega_in,
    input  logic              erro_in,
    input  logic              nivel_min,
    input  logic              nivel_max,
    output logic [MEF1_W-1:0] mef1,
    output logic              VE,
    output logic              valv_asp,
    output logic              valv_got,
    output logic              limpeza,
    output logic              alarme,
    output logic [CODE_W-1:0] erro_code
);

    localparam int unsigned REGAS_W = (N_REGAS_LIMP > 1) ? $clog2(N_REGAS_LIMP) : 1;

    estado_t            state_q, state_d;
    erro_t              code_q, code_d;
    logic [REGAS_W-1:0] cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               entry_q;
    logic               load_c, done_c;
    logic [CNT_W-1:0]   load_val_c;
    logic [1:0]         modo_c;

    timer_descendente #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .load_val (load_val_c),
        .tick     (tick),
        .done_c   (done_c)
    );

    // Next state, error code, completion counter and cleaning request
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        modo_c  = (state_q == S_REGA_ASP) ? REGA_MODO_ASP : REGA_MODO_GOT;
        unique case (state_q)
            S_IDLE: begin
                if (nivel_min && nivel_max) begin
                    state_d = S_ERRO;
                    code_d  = ERR_NIVEL;
                end else if (nivel_min) begin
                    state_d = S_ENCHENDO;
                end else if (pend_q) begin
                    state_d = S_LIMPEZA;
                end else if (asp_req && got_req) begin
                    state_d = S_ERRO;
                    code_d  = ERR_REQS;
                end else if (asp_req) begin
                    state_d = S_REGA_ASP;
                end else if (got_req) begin
                    state_d = S_REGA_GOT;
                end
            end
            S_ENCHENDO: begin
                if (nivel_min && nivel_max) begin
                    state_d = S_ERRO;
                    code_d  = ERR_NIVEL;
                end else if (nivel_max) begin
                    state_d = S_IDLE;
                end else if (done_c) begin
                    state_d = S_ERRO;
                    code_d  = ERR_NIVEL;
                end
            end
            S_REGA_ASP, S_REGA_GOT: begin
                // Validator output lags one cycle, so the mode check waits past entry
                if (erro_in) begin
                    state_d = S_ERRO;
                    code_d  = ERR_VALID;
                end else if (nivel_min) begin
                    state_d = S_ENCHENDO;
                end else if (!entry_q && (rega_in != modo_c)) begin
                    state_d = S_IDLE;
                end else if (done_c) begin
                    state_d = S_IDLE;
                    if (cnt_q == REGAS_W'(N_REGAS_LIMP - 1)) begin
                        cnt_d  = '0;
                        pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + REGAS_W'(1);
                    end
                end
            end
            S_LIMPEZA: begin
                if (done_c) begin
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                end
            end
            S_ERRO: begin
                if (!asp_req && !got_req && !erro_in && !(nivel_min && nivel_max)) begin
                    state_d = S_IDLE;
                    code_d  = ERR_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                code_d  = ERR_NONE;
            end
        endcase
    end

    // Timer reload on every state entry with that state's duration
    always_comb begin
        load_c     = (state_d != state_q);
        load_val_c = '0;
        case (state_d)
            S_ENCHENDO: load_val_c = CNT_W'(T_FILL);
            S_REGA_ASP: load_val_c = CNT_W'(T_ASP);
            S_REGA_GOT: load_val_c = CNT_W'(T_GOT);
            S_LIMPEZA:  load_val_c = CNT_W'(T_LIMP);
            default:    load_val_c = '0;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            code_q    <= ERR_NONE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            entry_q   <= 1'b0;
            mef1      <= MEF1_IDLE;
            VE        <= 1'b0;
            valv_asp  <= 1'b0;
            valv_got  <= 1'b0;
            limpeza   <= 1'b0;
            alarme    <= 1'b0;
            erro_code <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            entry_q   <= load_c;
            mef1      <= mef1_de(state_d);
            VE        <= (state_d == S_ENCHENDO);
            valv_asp  <= (state_d == S_REGA_ASP) || (state_d == S_LIMPEZA);
            valv_got  <= (state_d == S_REGA_GOT) || (state_d == S_LIMPEZA);
            limpeza   <= (state_d == S_LIMPEZA);
            alarme    <= (state_d == S_ERRO);
            erro_code <= (state_d == S_ERRO) ? code_d : ERR_NONE;
        end
    end

endmodule

// File: tb/tb_mef_irrigacao.sv
// Directed bench for mef_irrigacao with a per-cycle behavioural model and literal spot checks.
module tb_mef_irrigacao;

    localparam int T_ASP = 3, T_GOT = 5, T_LIMP = 2, T_FILL = 6, N_REGAS = 2;
    localparam int P_IDLE = 0, P_FILL = 1, P_ASP = 2, P_GOT = 3, P_CLEAN = 4, P_ERR = 5;

    logic       clk = 1'b0;
    logic       rst_n, tick, asp_req, got_req, erro_in, nivel_min, nivel_max;
    logic [1:0] rega_in;
    logic [1:0] mef1, erro_code;
    logic       VE, valv_asp, valv_got, limpeza, alarme;
    logic [8:0] dut_vec;

    int  n_checks = 0;
    int  n_err    = 0;
    bit  chk_en   = 1'b0;

    mef_irrigacao #(
        .T_ASP(T_ASP), .T_GOT(T_GOT), .T_LIMP(T_LIMP), .T_FILL(T_FILL),
        .N_REGAS_LIMP(N_REGAS), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .asp_req(asp_req), .got_req(got_req),
        .rega_in(rega_in), .erro_in(erro_in), .nivel_min(nivel_min), .nivel_max(nivel_max),
        .mef1(mef1), .VE(VE), .valv_asp(valv_asp), .valv_got(valv_got),
        .limpeza(limpeza), .alarme(alarme), .erro_code(erro_code)
    );

    always #5 clk = ~clk;

    assign dut_vec = {mef1, VE, valv_asp, valv_got, limpeza, alarme, erro_code};

    // Model: phase, ticks elapsed in phase, completions since last cleaning
    int ph = P_IDLE, ticks = 0, done_n = 0, ecode = 0;
    bit pend = 1'b0, fresh = 1'b0;

    function automatic bit expires(input int dur);
        return tick && (ticks + 1 == dur);
    endfunction

    always @(posedge clk) begin
        int nph;
        nph = ph;
        if (!rst_n) begin
            nph = P_IDLE; ecode = 0; done_n = 0; pend = 1'b0;
        end else begin
            case (ph)
                P_IDLE: begin
                    if (nivel_min && nivel_max) begin nph = P_ERR; ecode = 3; end
                    else if (nivel_min) nph = P_FILL;
                    else if (pend) nph = P_CLEAN;
                    else if (asp_req && got_req) begin nph = P_ERR; ecode = 2; end
                    else if (asp_req) nph = P_ASP;
                    else if (got_req) nph = P_GOT;
                end
                P_FILL: begin
                    if (nivel_min && nivel_max) begin nph = P_ERR; ecode = 3; end
                    else if (nivel_max) nph = P_IDLE;
                    else if (expires(T_FILL)) begin nph = P_ERR; ecode = 3; end
                end
                P_ASP, P_GOT: begin
                    if (erro_in) begin nph = P_ERR; ecode = 1; end
                    else if (nivel_min) nph = P_FILL;
                    else if (!fresh && rega_in != ((ph == P_ASP) ? 2'b10 : 2'b01)) nph = P_IDLE;
                    else if (expires((ph == P_ASP) ? T_ASP : T_GOT)) begin
                        nph = P_IDLE;
                        done_n++;
                        if (done_n == N_REGAS) begin done_n = 0; pend = 1'b1; end
                    end
                end
                P_CLEAN: if (expires(T_LIMP)) begin nph = P_IDLE; pend = 1'b0; end
                default: if (!asp_req && !got_req && !erro_in && !(nivel_min && nivel_max)) begin
                    nph = P_IDLE; ecode = 0;
                end
            endcase
        end
        if (nph != ph) begin ticks = 0; fresh = 1'b1; end
        else begin fresh = 1'b0; if (tick) ticks++; end
        ph = nph;
    end

    function automatic logic [8:0] expect_vec();
        logic [1:0] m;
        case (ph)
            P_FILL:       m = 2'b01;
            P_ASP, P_GOT: m = 2'b11;
            P_CLEAN:      m = 2'b10;
            default:      m = 2'b00;
        endcase
        return {m, ph == P_FILL, (ph == P_ASP) || (ph == P_CLEAN), (ph == P_GOT) || (ph == P_CLEAN),
                ph == P_CLEAN, ph == P_ERR, (ph == P_ERR) ? 2'(ecode) : 2'b00};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (dut_vec !== expect_vec()) begin
                n_err++;
                $display("FAIL model t=%0t outputs got=%b expected=%b", $time, dut_vec, expect_vec());
            end
        end
    end

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    // One request pulse; counts irrigation cycles and full cleaning cycles seen over n cycles
    task automatic run_req(input logic a, input int n, output int cr, output int cl);
        cr = 0; cl = 0;
        rega_in = a ? 2'b10 : 2'b01;
        asp_req = a; got_req = !a;
        repeat (n) begin
            nc();
            if (mef1 == 2'b11 && (a ? valv_asp : valv_got)) cr++;
            if (limpeza && valv_asp && valv_got && !VE && mef1 == 2'b10) cl++;
            asp_req = 1'b0; got_req = 1'b0;
        end
    endtask

    initial begin
        int cr, cl, c;
        rst_n = 1'b0; tick = 1'b1; asp_req = 1'b0; got_req = 1'b0; rega_in = 2'b00;
        erro_in = 1'b0; nivel_min = 1'b0; nivel_max = 1'b0;
        nc(); chk_en = 1'b1;
        nc();
        chk("reset_outputs", dut_vec, 9'd0);
        rst_n = 1'b1;

        run_req(1'b1, 8, cr, cl);  chk("asp_len", 9'(cr), 9'd3);
        run_req(1'b0, 12, cr, cl); chk("got_len", 9'(cr), 9'd5); chk("clean_len", 9'(cl), 9'd2);
        run_req(1'b0, 10, cr, cl); chk("no_clean_after_one", 9'(cl), 9'd0);
        run_req(1'b1, 12, cr, cl); chk("clean_after_two", 9'(cl), 9'd2);

        nivel_min = 1'b1; nc();
        chk("fill_ve_mef1", 9'({VE, mef1}), 9'b101);
        nivel_min = 1'b0; nc();
        nivel_max = 1'b1; nc();
        chk("fill_to_idle", 9'({VE, mef1}), 9'd0);
        nivel_max = 1'b0;

        nivel_min = 1'b1; c = 0;
        repeat (7) begin nc(); if (VE) c++; end
        chk("fill_timeout_len", 9'(c), 9'd6);
        chk("fill_timeout_code", 9'({alarme, erro_code}), 9'b111);
        nivel_min = 1'b0; nc();
        chk("fill_err_exit", 9'({alarme, erro_code, mef1}), 9'd0);

        asp_req = 1'b1; got_req = 1'b1; nc();
        chk("both_req_code", 9'({alarme, erro_code}), 9'b110);
        asp_req = 1'b0; nc();
        chk("err_held", 9'({alarme, erro_code}), 9'b110);
        got_req = 1'b0; nc();
        chk("both_req_exit", 9'({alarme, erro_code}), 9'd0);

        rega_in = 2'b01; got_req = 1'b1;
        nc(); got_req = 1'b0;
        nc(); nc(); nc();
        nc(); erro_in = 1'b1;
        nc();
        chk("erro_on_expiry", 9'({alarme, erro_code}), 9'b101);
        erro_in = 1'b0; nc();
        chk("erro_exit", 9'({alarme, mef1}), 9'd0);

        got_req = 1'b1;
        nc(); got_req = 1'b0;
        nc(); rega_in = 2'b00;
        nc();
        chk("mode_abort", 9'({mef1, valv_got}), 9'd0);
        rega_in = 2'b01; nc();

        run_req(1'b0, 10, cr, cl); chk("aborts_not_counted", 9'(cl), 9'd0);
        run_req(1'b0, 12, cr, cl); chk("clean_after_aborts", 9'(cl), 9'd2);

        rega_in = 2'b10; asp_req = 1'b1; c = 0;
        for (int i = 0; i < 10; i++) begin
            nc();
            if (valv_asp) c++;
            asp_req = 1'b0;
            tick = (i == 0 || i == 1) ? 1'b0 : 1'b1;
        end
        chk("tick_gap_len", 9'(c), 9'd5);

        asp_req = 1'b1;
        nc(); asp_req = 1'b0;
        nc(); nc(); nc();
        nivel_min = 1'b1; nc();
        chk("fill_before_clean", 9'({VE, limpeza}), 9'b10);
        rst_n = 1'b0; nc();
        chk("rst_in_fill", dut_vec, 9'd0);
        rst_n = 1'b1; nivel_min = 1'b0; c = 0;
        repeat (6) begin nc(); if (limpeza) c++; end
        chk("pend_cleared", 9'(c), 9'd0);

        asp_req = 1'b1;
        nc(); asp_req = 1'b0;
        nc(); rst_n = 1'b0;
        nc();
        chk("rst_in_asp", dut_vec, 9'd0);
        rst_n = 1'b1;
        repeat (3) nc();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
